// File: rtl/payload_char_decoder.sv
// Serialises 64-bit payload words into one byte per cycle, classifies each byte through a
// programmable 256-entry table and drives the shared sod/en/class/eod lines of the engine array.
//
// state  | meaning
// IDLE   | ready for the first word of a packet
// SOD    | issue the start-of-data token
// STREAM | issue bytes from the holding register; waits (en=0) on underrun
// FLUSH  | issue FLUSH_CYC class-zero enable cycles
// EOD    | issue the end-of-data token
module payload_char_decoder #(
   parameter int NUM_CLASS = 24,
   parameter int FLUSH_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [63:0]          s_axis_tdata,
   input  logic [7:0]           s_axis_tkeep,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   input  logic                 cfg_we,
   input  logic [7:0]           cfg_addr,
   input  logic [NUM_CLASS-1:0] cfg_data,
   output logic                 cfg_err,
   output logic                 sod,
   output logic                 en,
   output logic [NUM_CLASS-1:0] class_bus,
   output logic                 eod,
   output logic                 busy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SOD    = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_FLUSH  = 3'd3;
   localparam logic [2:0] ST_EOD    = 3'd4;

   localparam logic [2:0] TK_NONE  = 3'd0;
   localparam logic [2:0] TK_SOD   = 3'd1;
   localparam logic [2:0] TK_BYTE  = 3'd2;
   localparam logic [2:0] TK_FLUSH = 3'd3;
   localparam logic [2:0] TK_EOD   = 3'd4;

   localparam int              FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

   logic [2:0]           r_state;
   logic [63:0]          r_data;
   logic [3:0]           r_nbytes;
   logic                 r_last;
   logic [2:0]           r_idx;
   logic                 r_hold_vld;
   logic [FC_W-1:0]      r_flush_cnt;
   logic [2:0]           r_s1_kind;
   logic [7:0]           r_s1_addr;
   logic [2:0]           r_s2_kind;
   logic [NUM_CLASS-1:0] r_rd_data;
   logic                 r_cfg_err;
   logic [NUM_CLASS-1:0] r_table [256];

   logic [2:0] w_next;
   logic [2:0] w_kind;
   logic       w_tready_fsm;
   logic       w_accept;
   logic       w_word_done;
   logic       w_adv_idx;
   logic [3:0] w_keep_cnt;
   logic [7:0] w_byte;
   logic       w_busy;
   logic       w_cfg_ok;

   always_comb begin
      w_keep_cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_keep_cnt = w_keep_cnt + {3'b000, s_axis_tkeep[i]};
      end
   end

   assign w_byte = r_data[{r_idx, 3'b000} +: 8];

   always_comb begin
      w_next       = r_state;
      w_kind       = TK_NONE;
      w_tready_fsm = 1'b0;
      w_word_done  = 1'b0;
      w_adv_idx    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_tready_fsm = 1'b1;
            if (w_accept) w_next = ST_SOD;
         end
         ST_SOD: begin
            w_kind = TK_SOD;
            w_next = (r_nbytes == 4'd0 && r_last) ? ST_FLUSH : ST_STREAM;
         end
         ST_STREAM: begin
            if (!r_hold_vld) begin
               w_tready_fsm = 1'b1;
            end else if (r_nbytes == 4'd0) begin
               w_word_done = 1'b1;
               if (r_last) w_next = ST_FLUSH;
               else        w_tready_fsm = 1'b1;
            end else begin
               w_kind = TK_BYTE;
               if ({1'b0, r_idx} == r_nbytes - 4'd1) begin
                  w_word_done = 1'b1;
                  if (r_last) w_next = ST_FLUSH;
                  else        w_tready_fsm = 1'b1;
               end else begin
                  w_adv_idx = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            w_kind = TK_FLUSH;
            if (r_flush_cnt == '0) w_next = ST_EOD;
         end
         ST_EOD: begin
            w_kind = TK_EOD;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign s_axis_tready = w_tready_fsm & ~rst;
   assign w_accept      = s_axis_tvalid & s_axis_tready;
   assign w_busy        = (r_state != ST_IDLE) || (r_s1_kind != TK_NONE) || (r_s2_kind != TK_NONE);
   assign w_cfg_ok      = cfg_we & ~w_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_data      <= '0;
         r_nbytes    <= '0;
         r_last      <= 1'b0;
         r_idx       <= '0;
         r_hold_vld  <= 1'b0;
         r_flush_cnt <= '0;
         r_s1_kind   <= TK_NONE;
         r_s1_addr   <= '0;
         r_s2_kind   <= TK_NONE;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_data     <= s_axis_tdata;
            r_nbytes   <= w_keep_cnt;
            r_last     <= s_axis_tlast;
            r_idx      <= '0;
            r_hold_vld <= 1'b1;
         end else if (w_word_done) begin
            r_hold_vld <= 1'b0;
         end else if (w_adv_idx) begin
            r_idx <= r_idx + 3'd1;
         end
         // Down-counter is loaded on FLUSH entry; terminal count hands over to EOD.
         if (w_next == ST_FLUSH && r_state != ST_FLUSH) r_flush_cnt <= FC_LOAD;
         else if (r_state == ST_FLUSH)                  r_flush_cnt <= r_flush_cnt - 1'b1;
         r_s1_kind <= w_kind;
         r_s1_addr <= w_byte;
         r_s2_kind <= r_s1_kind;
         r_cfg_err <= cfg_we & w_busy;
      end
   end

   // Table RAM is deliberately left out of reset so it maps onto block memory.
   always_ff @(posedge clk) begin
      if (w_cfg_ok) r_table[cfg_addr] <= cfg_data;
      r_rd_data <= r_table[r_s1_addr];
   end

   assign sod       = (r_s2_kind == TK_SOD);
   assign eod       = (r_s2_kind == TK_EOD);
   assign en        = (r_s2_kind == TK_BYTE) || (r_s2_kind == TK_FLUSH);
   assign class_bus = (r_s2_kind == TK_BYTE) ? r_rd_data : '0;
   assign cfg_err   = r_cfg_err;
   assign busy      = w_busy;

endmodule

// File: tb/tb_payload_char_decoder.sv
// Scoreboard bench for payload_char_decoder: stimulus pushes expected tokens with their
// expected output cycle, a negedge monitor pops and compares whenever sod/en/eod is high.
module tb_payload_char_decoder;
   localparam int NC = 24;
   localparam int FC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [63:0]   s_axis_tdata = '0;
   logic [7:0]    s_axis_tkeep = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tready;
   logic          cfg_we = 1'b0;
   logic [7:0]    cfg_addr = '0;
   logic [NC-1:0] cfg_data = '0;
   logic          cfg_err, sod, en, eod, busy;
   logic [NC-1:0] class_bus;

   payload_char_decoder #(.NUM_CLASS(NC), .FLUSH_CYC(FC)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
      .sod(sod), .en(en), .class_bus(class_bus), .eod(eod), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            c;
      logic [NC+2:0] v;
   } exp_t;
   exp_t q[$];
   exp_t e;

   logic [NC-1:0] model_tbl [256];
   int  next_cyc;
   bit  tready_seen [4096];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic void push(input int c, input logic s, input logic n, input logic d,
                                input logic [NC-1:0] cl);
      exp_t x;
      x.c = c;
      x.v = {s, n, d, cl};
      q.push_back(x);
   endfunction

   always @(negedge clk) begin
      if (cyc < 4096) tready_seen[cyc] = s_axis_tready;
      if (!rst) begin
         if (sod || en || eod) begin
            if (q.size() == 0) begin
               chk("unexpected_token", {sod, en, eod, class_bus}, '0);
            end else begin
               e = q.pop_front();
               chk("tok_cycle", cyc, e.c);
               chk("tok_value", {sod, en, eod, class_bus}, e.v);
            end
         end else begin
            chk("idle_class", class_bus, '0);
         end
      end
   end

   // Called just after a rising edge; returns just after a rising edge.
   task automatic send_word(input logic [63:0] data, input logic [7:0] keep, input logic last,
                            input bit first, output int acc);
      int n;
      bit got;
      s_axis_tdata  = data;
      s_axis_tkeep  = keep;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      got = 1'b0;
      acc = -1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (s_axis_tready) begin
            got = 1'b1;
            acc = cyc;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!got) begin
         chk("accept_timeout", 0, 1);
         s_axis_tvalid = 1'b0;
         return;
      end
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(keep[i]);
      if (first) begin
         push(acc + 3, 1'b1, 1'b0, 1'b0, '0);
         next_cyc = acc + 4;
      end else begin
         next_cyc = acc + 3;
      end
      for (int i = 0; i < n; i++) begin
         push(next_cyc, 1'b0, 1'b1, 1'b0, model_tbl[data[8*i +: 8]]);
         next_cyc++;
      end
      if (last) begin
         for (int f = 0; f < FC; f++) begin
            push(next_cyc, 1'b0, 1'b1, 1'b0, '0);
            next_cyc++;
         end
         push(next_cyc, 1'b0, 1'b0, 1'b1, '0);
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [NC-1:0] d, input bit expect_ok);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      @(negedge clk);
      chk("cfg_err", cfg_err, {63'd0, !expect_ok});
      @(posedge clk); #1;
      @(negedge clk);
      chk("cfg_err_end", cfg_err, 0);
      @(posedge clk); #1;
      if (expect_ok) model_tbl[a] = d;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
         @(posedge clk); #1;
      end
      chk("idle_timeout", ok, 1);
      chk("queue_drained", q.size(), 0);
   endtask

   initial begin
      int a, a2, cnt;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_outputs", {sod, en, eod, cfg_err, busy, s_axis_tready}, 0);
      chk("rst_class", class_bus, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("tready_after_rst", s_axis_tready, 1);
      @(posedge clk); #1;

      cfg_write(8'h76, 24'h200000, 1'b1);
      cfg_write(8'h56, 24'h200000, 1'b1);
      cfg_write(8'h61, 24'h008000, 1'b1);
      cfg_write(8'h72, 24'h400000, 1'b1);
      for (int i = 0; i < 10; i++) cfg_write(8'h30 + 8'(i), 24'h1 << i, 1'b1);

      // "var": sod at +3, bytes +4..+6, flush +7,+8, eod +9
      send_word(64'hDEAD_BEEF_DE72_6176, 8'h07, 1'b1, 1'b1, a);
      @(negedge clk);
      chk("busy_in_pkt", busy, 1);
      @(posedge clk); #1;
      wait_idle();

      // 10 bytes back-to-back; second word accepted in the cycle issuing byte 7
      send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b0, 1'b1, a);
      send_word(64'hFFFF_FFFF_FFFF_3938, 8'h03, 1'b1, 1'b0, a2);
      chk("b2b_accept_cycle", a2 - a, 9);
      wait_idle();
      cnt = 0;
      for (int c = a + 1; c <= a + 14; c++) cnt += int'(tready_seen[c]);
      chk("b2b_tready_count", cnt, 1);
      chk("b2b_tready_byte7", tready_seen[a + 9], 1);

      // second word 5 cycles late: en gap of 5 between bytes 7 and 8
      send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b0, 1'b1, a);
      repeat (13) @(posedge clk);
      #1;
      send_word(64'h0000_0000_0000_3938, 8'h03, 1'b1, 1'b0, a2);
      chk("underrun_accept", a2 - a, 14);
      wait_idle();

      // empty tlast word
      send_word(64'h0, 8'h00, 1'b1, 1'b1, a);
      wait_idle();

      // full 8-byte single word
      send_word(64'h3938_3736_3534_3332, 8'hFF, 1'b1, 1'b1, a);
      wait_idle();

      // rejected write while busy, table keeps old value
      send_word(64'h0000_0000_0000_6156, 8'h03, 1'b1, 1'b1, a);
      cfg_write(8'h61, 24'h000001, 1'b0);
      wait_idle();
      send_word(64'h0000_0000_0000_0061, 8'h01, 1'b1, 1'b1, a);
      wait_idle();
      cfg_write(8'h72, 24'h000008, 1'b1);
      send_word(64'h0000_0000_0000_0072, 8'h01, 1'b1, 1'b1, a);
      wait_idle();

      // reset mid-stream
      send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b0, 1'b1, a);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midrst_outputs", {sod, en, eod, busy, s_axis_tready}, 0);
      chk("midrst_class", class_bus, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_hold", {sod, en, eod, busy, s_axis_tready}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      @(negedge clk);
      chk("post_rst_idle", {busy, s_axis_tready}, 2'b01);
      @(posedge clk); #1;
      send_word(64'h0000_0000_0072_6176, 8'h07, 1'b1, 1'b1, a);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
